// File: rtl/regdst_hazard_ctrl.sv
// Destination-register select plus EX/MEM/WB scoreboard for a 5-stage pipeline.
// It produces the load-use stall, the EX operand forward selects and the register-file write control.
module regdst_hazard_ctrl #(
  parameter logic [4:0] XP_REG = 5'd30,
  parameter logic [4:0] RA_REG = 5'd31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic [1:0] id_regdst,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       hold,
  input  logic       flush,
  output logic [4:0] id_dst,
  output logic       stall,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       wb_we,
  output logic [4:0] wb_addr
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
  } ex_slot_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
  } slot_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  ex_slot_t ex_q,  ex_d;
  slot_t    mem_q, mem_d;
  slot_t    wb_q,  wb_d;

  logic mem_wr_s;
  logic wb_wr_s;
  logic ex_wr_s;
  logic unused_s;

  // A slot writes the register file only if it is live and targets a non-zero register.
  function automatic logic slot_writes(input logic valid, input logic regwrite,
                                       input logic [4:0] dst);
    return valid & regwrite & (dst != 5'd0);
  endfunction

  // MEM beats WB because it holds the younger result.
  function automatic logic [1:0] fwd_select(input logic ex_use, input logic [4:0] src,
                                            input logic mem_wr, input logic [4:0] mem_dst,
                                            input logic wb_wr, input logic [4:0] wb_dst);
    logic [1:0] sel;
    if (ex_use && mem_wr && (mem_dst == src)) begin
      sel = FWD_MEM;
    end else if (ex_use && wb_wr && (wb_dst == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Destination register decode.
  always_comb begin
    id_dst = id_rt;
    case (id_regdst)
      2'd0:    id_dst = id_rt;
      2'd1:    id_dst = id_rd;
      2'd2:    id_dst = RA_REG;
      2'd3:    id_dst = XP_REG;
      default: id_dst = id_rt;
    endcase
  end

  assign ex_wr_s  = slot_writes(ex_q.valid,  ex_q.regwrite,  ex_q.dst);
  assign mem_wr_s = slot_writes(mem_q.valid, mem_q.regwrite, mem_q.dst);
  assign wb_wr_s  = slot_writes(wb_q.valid,  wb_q.regwrite,  wb_q.dst);

  // memread only matters while an instruction sits in EX.
  assign unused_s = ^{mem_q.memread, wb_q.memread};

  // Hazard outputs, all derived from slot state so reset forces them to idle.
  always_comb begin
    stall = id_valid & ex_wr_s & ex_q.memread &
            ((id_uses_rs & (id_rs == ex_q.dst)) | (id_uses_rt & (id_rt == ex_q.dst)));
    fwd_a = fwd_select(ex_q.valid & ex_q.uses_rs, ex_q.rs,
                       mem_wr_s, mem_q.dst, wb_wr_s, wb_q.dst);
    fwd_b = fwd_select(ex_q.valid & ex_q.uses_rt, ex_q.rt,
                       mem_wr_s, mem_q.dst, wb_wr_s, wb_q.dst);
    wb_we = wb_wr_s;
    if (wb_q.valid) begin
      wb_addr = wb_q.dst;
    end else begin
      wb_addr = 5'd0;
    end
  end

  // Pipeline advance; hold freezes everything except a flush of EX.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!hold) begin
      wb_d           = mem_q;
      mem_d.valid    = ex_q.valid;
      mem_d.dst      = ex_q.dst;
      mem_d.regwrite = ex_q.regwrite;
      mem_d.memread  = ex_q.memread;
      if (flush || stall || !id_valid) begin
        ex_d = '0;
      end else begin
        ex_d.valid    = 1'b1;
        ex_d.dst      = id_dst;
        ex_d.regwrite = id_regwrite;
        ex_d.memread  = id_memread;
        ex_d.rs       = id_rs;
        ex_d.rt       = id_rt;
        ex_d.uses_rs  = id_uses_rs;
        ex_d.uses_rt  = id_uses_rt;
      end
    end else if (flush) begin
      ex_d.valid = 1'b0;
    end else begin
      ex_d = ex_q;
    end
  end

  // Slot registers; reset discards every in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  regdst_hazard_ctrl_chk u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .id_valid (id_valid),
    .stall    (stall),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b)
  );

endmodule

// Invariant checks on the hazard outputs.
module regdst_hazard_ctrl_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       id_valid,
  input logic       stall,
  input logic [1:0] fwd_a,
  input logic [1:0] fwd_b
);

  a_fwd_a_legal: assert property (@(posedge clk) disable iff (!rst_n) fwd_a != 2'b11);
  a_fwd_b_legal: assert property (@(posedge clk) disable iff (!rst_n) fwd_b != 2'b11);
  a_stall_needs_id: assert property (@(posedge clk) disable iff (!rst_n) stall |-> id_valid);

endmodule

// File: tb/tb_regdst_hazard_ctrl.sv
// Directed-vector bench: the driver pushes hand-computed expectations, and a monitor
// pops and compares them at the falling edge or on a mid-cycle probe.
module tb_regdst_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [1:0] id_regdst;
  logic       id_regwrite, id_memread, id_uses_rs, id_uses_rt;
  logic       hold, flush;
  logic [4:0] id_dst;
  logic       stall;
  logic [1:0] fwd_a, fwd_b;
  logic       wb_we;
  logic [4:0] wb_addr;
  logic       probe;

  int checks;
  int errors;

  logic [15:0] exp_q[$];
  string       name_q[$];

  regdst_hazard_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_regdst   (id_regdst),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .hold        (hold),
    .flush       (flush),
    .id_dst      (id_dst),
    .stall       (stall),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push_exp(input string nm, input int e_dst, input int e_st,
                          input int e_fa, input int e_fb, input int e_we, input int e_wa);
    exp_q.push_back({5'(e_dst), 1'(e_st), 2'(e_fa), 2'(e_fb), 1'(e_we), 5'(e_wa)});
    name_q.push_back(nm);
  endtask

  task automatic step(input string nm, input int v, input int rs, input int rt, input int rd,
                      input int rdst, input int rw, input int mr, input int urs, input int urt,
                      input int hd, input int fl,
                      input int e_dst, input int e_st, input int e_fa, input int e_fb,
                      input int e_we, input int e_wa);
    @(posedge clk);
    #1;
    id_valid    = 1'(v);
    id_rs       = 5'(rs);
    id_rt       = 5'(rt);
    id_rd       = 5'(rd);
    id_regdst   = 2'(rdst);
    id_regwrite = 1'(rw);
    id_memread  = 1'(mr);
    id_uses_rs  = 1'(urs);
    id_uses_rt  = 1'(urt);
    hold        = 1'(hd);
    flush       = 1'(fl);
    push_exp(nm, e_dst, e_st, e_fa, e_fb, e_we, e_wa);
  endtask

  task automatic idle(input string nm, input int e_fa, input int e_fb, input int e_we,
                      input int e_wa);
    step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_fa, e_fb, e_we, e_wa);
  endtask

  // Assert reset between edges and check outputs before the next rising edge.
  task automatic mid_reset(input string nm, input int e_dst);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    push_exp(nm, e_dst, 0, 0, 0, 0, 0);
    #1 probe = 1'b1;
    #1 probe = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compare whenever an expectation is pending at a sample point.
  initial begin
    logic [15:0] e;
    logic [15:0] a;
    string       nm;
    forever begin
      @(negedge clk or posedge probe);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {id_dst, stall, fwd_a, fwd_b, wb_we, wb_addr};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got dst=%0d stall=%0b fwd_a=%0b fwd_b=%0b wb_we=%0b wb_addr=%0d, expected dst=%0d stall=%0b fwd_a=%0b fwd_b=%0b wb_we=%0b wb_addr=%0d",
                   nm, a[15:11], a[10], a[9:8], a[7:6], a[5], a[4:0],
                   e[15:11], e[10], e[9:8], e[7:6], e[5], e[4:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    probe = 1'b0;
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_regdst = 2'd0;
    id_regwrite = 1'b0; id_memread = 1'b0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    hold = 1'b0; flush = 1'b0;

    step("reset_outputs", 0,0,0,0,3, 0,0,0,0, 0,0, 30,0,0,0,0,0);
    release_rst();

    // ALU result forwarded from MEM
    step("add_rd5",        1,1,2,5,1, 1,0,1,1, 0,0, 5,0,0,0,0,0);
    step("add_rs5",        1,5,3,6,1, 1,0,1,1, 0,0, 6,0,0,0,0,0);
    idle("fwd_a_mem",      1,0,0,0);
    idle("no_fwd_after",   0,0,1,5);
    idle("wb_add_rd6",     0,0,1,6);

    // load-use: one stall, one bubble, then forward from WB
    step("lw_rt8",         1,2,8,0,0, 1,1,1,0, 0,0, 8,0,0,0,0,0);
    step("load_use_stall", 1,8,9,10,1, 1,0,1,1, 0,0, 10,1,0,0,0,0);
    step("stall_release",  1,8,9,10,1, 1,0,1,1, 0,0, 10,0,0,0,0,0);
    idle("fwd_a_wb_load",  2,0,1,8);
    idle("idle_after_ld",  0,0,0,0);

    // link registers
    step("jal_dst31",      1,0,0,0,2, 1,0,0,0, 0,0, 31,0,0,0,1,10);
    step("use_rs31_dst30", 1,31,0,0,3, 0,0,1,0, 0,0, 30,0,0,0,0,0);
    idle("fwd_a_ra_mem",   1,0,0,0);
    idle("wb_ra",          0,0,1,31);

    // register 0 never hazards
    step("lw_r0_wb_nowr",  1,1,0,0,0, 1,1,1,0, 0,0, 0,0,0,0,0,30);
    step("use_r0_nostall", 1,0,0,0,1, 1,0,1,1, 0,0, 0,0,0,0,0,0);
    idle("r0_no_fwd",      0,0,0,0);
    idle("r0_no_wb_we",    0,0,0,0);

    // MEM priority over WB, and fwd_b from WB
    step("i1_rd7",         1,0,0,7,1, 1,0,0,0, 0,0, 7,0,0,0,0,0);
    step("i2_rd7",         1,0,0,7,1, 1,0,0,0, 0,0, 7,0,0,0,0,0);
    step("i3_rs7_rt7",     1,7,7,11,1, 1,0,1,1, 0,0, 11,0,0,0,0,0);
    step("fwd_mem_prio",   1,12,7,13,1, 1,0,1,1, 0,0, 13,0,1,1,1,7);
    idle("fwd_b_wb",       0,2,1,7);

    // hold for three cycles, flush in the second
    step("j1_rd14",        1,0,0,14,1, 1,0,0,0, 0,0, 14,0,0,0,1,11);
    step("j2_rs14",        1,14,0,15,1, 1,0,1,0, 0,0, 15,0,0,0,1,13);
    step("j3_rd16",        1,0,0,16,1, 1,0,0,0, 0,0, 16,0,1,0,0,0);
    step("hold_c1",        1,15,0,17,1, 1,0,1,0, 1,0, 17,0,0,0,1,14);
    step("hold_c2_flush",  1,15,0,17,1, 1,0,1,0, 1,1, 17,0,0,0,1,14);
    step("hold_c3",        1,15,0,17,1, 1,0,1,0, 1,0, 17,0,0,0,1,14);
    step("hold_release",   1,15,0,17,1, 1,0,1,0, 0,0, 17,0,0,0,1,14);
    idle("fwd_a_wb_post",  2,0,1,15);
    idle("flushed_no_we",  0,0,0,0);

    // mid-operation reset with three live slots and a pending stall
    step("k1_rd20",        1,0,0,20,1, 1,0,0,0, 0,0, 20,0,0,0,1,17);
    step("k2_rd21",        1,0,0,21,1, 1,0,0,0, 0,0, 21,0,0,0,0,0);
    step("k3_lw_rt22",     1,20,22,0,0, 1,1,1,1, 0,0, 22,0,0,0,0,0);
    step("k4_stall_fwd",   1,22,21,23,1, 1,0,1,1, 0,0, 23,1,2,0,1,20);
    mid_reset("mid_reset_clears", 23);
    step("held_in_reset",  1,22,21,23,1, 1,0,1,1, 0,0, 23,0,0,0,0,0);
    release_rst();
    idle("post_reset_ex",  0,0,0,0);
    idle("post_reset_mem", 0,0,0,0);
    idle("post_reset_wb",  0,0,1,23);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
